// File: rtl/fre_div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fre_div_pkg                                                          |
// | Shared types and defaults for the scheduled clock-enable divider.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fre_div_pkg;

  localparam int CFG_W  = 8;
  localparam int DEF_LW = 2;
  localparam int DEF_HW = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_e;

  typedef struct packed {
    logic [CFG_W-1:0] lw;
    logic [CFG_W-1:0] hw;
  } cfg_t;

  // A zero-length phase would never end, so it is promoted to one cycle.
  function automatic cfg_t clamp_cfg(input cfg_t c);
    cfg_t r;
    r = c;
    if (c.lw == '0) r.lw = CFG_W'(1);
    if (c.hw == '0) r.hw = CFG_W'(1);
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fre_div_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fre_div_core                                                         |
// | Phase counter and registered divided output for one low/high period. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fre_div_core #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          run_i,
  input  logic [CW-1:0] lw_i,
  input  logic [CW-1:0] hw_i,
  output logic          phase_end_o,
  output logic          out_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;

  // cnt_q holds the 1-based cycle index within the current phase.
  assign phase_end_o = run_i & (cnt_q == (out_q ? hw_i : lw_i));
  assign out_o       = out_q;

  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    if (load_i) begin
      cnt_d = CW'(1);
      out_d = 1'b0;
    end else if (!run_i) begin
      cnt_d = '0;
      out_d = 1'b0;
    end else if (phase_end_o) begin
      cnt_d = CW'(1);
      out_d = ~out_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fre_div_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fre_div_sched                                                        |
// | Start/stop/burst scheduler with boundary-aligned config updates.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fre_div_sched
  import fre_div_pkg::*;
#(
  parameter int CW     = fre_div_pkg::CFG_W,
  parameter int PCW    = 16,
  parameter int DEF_LW = fre_div_pkg::DEF_LW,
  parameter int DEF_HW = fre_div_pkg::DEF_HW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CW-1:0]  cfg_lw,
  input  logic [CW-1:0]  cfg_hw,
  input  logic           start,
  input  logic           stop,
  input  logic [PCW-1:0] burst_len,
  output logic           busy,
  output logic           out_fre_divn,
  output logic           period_done,
  output logic           burst_done
);

  state_e         state_q;
  logic           stop_pend_q;
  logic [PCW-1:0] period_cnt_q;
  logic [PCW-1:0] burst_len_q;
  cfg_t           active_q;
  cfg_t           shadow_q;
  logic           shadow_full_q;

  cfg_t           cfg_in;
  logic           cfg_fire;
  logic           phase_end;
  logic           go;
  logic           burst_hit;
  logic           run_end;
  logic           core_load;
  logic [PCW-1:0] cnt_inc;

  assign cfg_in      = '{lw: cfg_lw, hw: cfg_hw};
  assign busy        = (state_q != ST_IDLE);
  assign cfg_ready   = ~shadow_full_q;
  assign cfg_fire    = cfg_valid & cfg_ready;
  assign period_done = (state_q == ST_HIGH) & phase_end;
  assign cnt_inc     = period_cnt_q + PCW'(1);
  assign burst_hit   = period_done & (burst_len_q != '0) & (cnt_inc == burst_len_q);
  assign burst_done  = burst_hit;
  assign run_end     = period_done & (stop_pend_q | burst_hit);
  assign go          = (state_q == ST_IDLE) & start;
  // Every LOW entry restarts the core and is the only point the shadow is applied.
  assign core_load   = go | (period_done & ~run_end);

  fre_div_core #(.CW(CW)) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (core_load),
    .run_i       (busy),
    .lw_i        (active_q.lw),
    .hw_i        (active_q.hw),
    .phase_end_o (phase_end),
    .out_o       (out_fre_divn)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      stop_pend_q   <= 1'b0;
      period_cnt_q  <= '0;
      burst_len_q   <= '0;
      active_q      <= '{lw: CW'(DEF_LW), hw: CW'(DEF_HW)};
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q      <= ST_LOW;
            period_cnt_q <= '0;
            burst_len_q  <= burst_len;
          end
        end
        ST_LOW: begin
          if (stop)      stop_pend_q <= 1'b1;
          if (phase_end) state_q     <= ST_HIGH;
        end
        ST_HIGH: begin
          if (stop) stop_pend_q <= 1'b1;
          if (period_done) begin
            if (run_end) begin
              state_q     <= ST_IDLE;
              stop_pend_q <= 1'b0;
            end else begin
              state_q <= ST_LOW;
            end
            // Continuous runs keep the counter parked at zero.
            if (burst_len_q != '0) period_cnt_q <= cnt_inc;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Shadow copy and a new accept are exclusive: accept needs an empty shadow.
      if (core_load && shadow_full_q) begin
        active_q      <= clamp_cfg(shadow_q);
        shadow_full_q <= 1'b0;
      end
      if (cfg_fire) begin
        if (!busy) begin
          active_q <= clamp_cfg(cfg_in);
        end else begin
          shadow_q      <= cfg_in;
          shadow_full_q <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fre_div_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fre_div_sched                                                     |
// | Table-driven and directed checks for fre_div_sched.                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_fre_div_sched;

  logic        clk;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_lw;
  logic [7:0]  cfg_hw;
  logic        start;
  logic        stop;
  logic [15:0] burst_len;
  logic        busy;
  logic        out_fre_divn;
  logic        period_done;
  logic        burst_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       st;
    logic       sp;
    logic       cv;
    logic [7:0] lw;
    logic [7:0] hw;
    logic       eo;
    logic       eb;
    logic       epd;
    logic       er;
  } vec_t;

  vec_t vecs[$];

  fre_div_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_lw       (cfg_lw),
    .cfg_hw       (cfg_hw),
    .start        (start),
    .stop         (stop),
    .burst_len    (burst_len),
    .busy         (busy),
    .out_fre_divn (out_fre_divn),
    .period_done  (period_done),
    .burst_done   (burst_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0b expected %0b", name, idx, act, exp);
    end
  endtask

  function automatic void add(input logic st, input logic sp, input logic cv,
                              input logic [7:0] lw, input logic [7:0] hw,
                              input logic eo, input logic eb, input logic epd,
                              input logic er);
    vec_t v;
    v.st = st; v.sp = sp; v.cv = cv; v.lw = lw; v.hw = hw;
    v.eo = eo; v.eb = eb; v.epd = epd; v.er = er;
    vecs.push_back(v);
  endfunction

  initial begin
    // Default config {2,3}: start, two periods, stop mid-LOW, start+stop in IDLE.
    for (int k = 0; k < 10; k++)
      add(k == 0, 0, 0, 0, 0, (k % 5) >= 2, 1, (k % 5) == 4, 1);
    add(0,0,0,0,0, 0,1,0,1);
    add(0,1,0,0,0, 0,1,0,1);
    add(0,0,0,0,0, 1,1,0,1);
    add(0,0,0,0,0, 1,1,0,1);
    add(0,0,0,0,0, 1,1,1,1);
    add(0,0,0,0,0, 0,0,0,1);
    add(0,0,0,0,0, 0,0,0,1);
    add(1,1,0,0,0, 0,1,0,1);
    add(0,0,0,0,0, 0,1,0,1);
    add(0,0,0,0,0, 1,1,0,1);
    add(0,0,0,0,0, 1,1,0,1);
    add(0,0,0,0,0, 1,1,1,1);
    add(0,0,0,0,0, 0,1,0,1);
    add(0,1,0,0,0, 0,1,0,1);
    add(0,0,0,0,0, 1,1,0,1);
    add(0,0,0,0,0, 1,1,0,1);
    add(0,0,0,0,0, 1,1,1,1);
    add(0,0,0,0,0, 0,0,0,1);
    // Config {4,1} written while idle, then a run with stop.
    add(0,0,1,4,1, 0,0,0,1);
    add(1,0,0,0,0, 0,1,0,1);
    add(0,0,0,0,0, 0,1,0,1);
    add(0,0,0,0,0, 0,1,0,1);
    add(0,0,0,0,0, 0,1,0,1);
    add(0,0,0,0,0, 1,1,1,1);
    add(0,0,0,0,0, 0,1,0,1);
    add(0,1,0,0,0, 0,1,0,1);
    add(0,0,0,0,0, 0,1,0,1);
    add(0,0,0,0,0, 0,1,0,1);
    add(0,0,0,0,0, 1,1,1,1);
    add(0,0,0,0,0, 0,0,0,1);
    // Running {2,3}: offer {1,1} in LOW cycle 1, then a stalled {3,1} offer.
    add(0,0,1,2,3, 0,0,0,1);
    add(1,0,0,0,0, 0,1,0,1);
    add(0,0,1,1,1, 0,1,0,0);
    add(0,0,1,3,1, 1,1,0,0);
    add(0,0,1,3,1, 1,1,0,0);
    add(0,0,1,3,1, 1,1,1,0);
    add(0,0,1,3,1, 0,1,0,1);
    add(0,0,1,3,1, 1,1,1,0);
    add(0,0,0,0,0, 0,1,0,1);
    add(0,0,0,0,0, 0,1,0,1);
    add(0,0,0,0,0, 0,1,0,1);
    add(0,0,0,0,0, 1,1,1,1);
    add(0,0,0,0,0, 0,1,0,1);
    add(0,1,0,0,0, 0,1,0,1);
    add(0,0,0,0,0, 0,1,0,1);
    add(0,0,0,0,0, 1,1,1,1);
    add(0,0,0,0,0, 0,0,0,1);

    rst_n = 1'b0; cfg_valid = 1'b0; cfg_lw = '0; cfg_hw = '0;
    start = 1'b0; stop = 1'b0; burst_len = '0;
    tick();
    tick();
    chk("rst_out",   0, out_fre_divn, 1'b0);
    chk("rst_busy",  0, busy,         1'b0);
    chk("rst_pd",    0, period_done,  1'b0);
    chk("rst_bd",    0, burst_done,   1'b0);
    chk("rst_ready", 0, cfg_ready,    1'b1);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].st; stop = vecs[i].sp; cfg_valid = vecs[i].cv;
      cfg_lw = vecs[i].lw; cfg_hw = vecs[i].hw;
      tick();
      chk("vec_out",   i, out_fre_divn, vecs[i].eo);
      chk("vec_busy",  i, busy,         vecs[i].eb);
      chk("vec_pd",    i, period_done,  vecs[i].epd);
      chk("vec_ready", i, cfg_ready,    vecs[i].er);
      chk("vec_bd",    i, burst_done,   1'b0);
    end
    start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;

    // Burst of 3 periods with {2,3}; burst_len changed after start must not matter.
    cfg_valid = 1'b1; cfg_lw = 8'd2; cfg_hw = 8'd3;
    tick();
    cfg_valid = 1'b0; start = 1'b1; burst_len = 16'd3;
    tick();
    start = 1'b0; burst_len = 16'd0;
    for (int k = 0; k < 15; k++) begin
      if (k > 0) tick();
      chk("burst_out",  k, out_fre_divn, (k % 5) >= 2);
      chk("burst_pd",   k, period_done,  (k % 5) == 4);
      chk("burst_bd",   k, burst_done,   k == 14);
      chk("burst_busy", k, busy,         1'b1);
    end
    tick();
    chk("burst_end_busy", 15, busy,         1'b0);
    chk("burst_end_out",  15, out_fre_divn, 1'b0);
    chk("burst_end_bd",   15, burst_done,   1'b0);

    // Zero-length config clamps to {1,1}; then asynchronous reset mid-HIGH.
    cfg_valid = 1'b1; cfg_lw = 8'd0; cfg_hw = 8'd0;
    tick();
    cfg_valid = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick();
      chk("zero_out", k, out_fre_divn, k[0]);
      chk("zero_pd",  k, period_done,  k[0]);
    end
    rst_n = 1'b0;
    #1;
    chk("arst_out",   0, out_fre_divn, 1'b0);
    chk("arst_busy",  0, busy,         1'b0);
    chk("arst_ready", 0, cfg_ready,    1'b1);
    tick();
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      chk("post_rst_out", k, out_fre_divn, (k % 5) >= 2);
      chk("post_rst_pd",  k, period_done,  k == 4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
